// File: rtl/cmul_pkg.sv
// rtl/cmul_pkg.sv - shared constants and types for the sequential complex multiplier
package cmul_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Opcode bit1 selects the adder, bit0 selects subtract
  localparam logic [2:0] OP_MUL = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  localparam logic [31:0] FP_ONE    = 32'h3F80_0000;
  localparam logic [2:0]  NUM_STEPS = 3'd6;

endpackage

// File: rtl/cplx_mul_seq.sv
// rtl/cplx_mul_seq.sv - complex multiply y=a*w over one shared external FPU, one op per cycle
// Optional unity-twiddle bypass: CMUL_UNITY_SKIP_EN
module cplx_mul_seq
  import cmul_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_re,
  input  logic [31:0] a_im,
  input  logic [31:0] w_re,
  input  logic [31:0] w_im,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y_re,
  output logic [31:0] y_im,
  output logic [31:0] fpu_in1,
  output logic [31:0] fpu_in2,
  output logic        fpu_en,
  output logic [2:0]  fpu_opcode,
  input  logic [31:0] fpu_out
);

  state_t      state;
  logic [2:0]  step;
  logic [31:0] ar_q, ai_q, wr_q, wi_q;
  logic [31:0] p0, p1, p2, p3;
  logic        out_valid_q;
  logic        unity_hit;

`ifdef CMUL_UNITY_SKIP_EN
  assign unity_hit = (w_re == FP_ONE) && (w_im == 32'h0);
`else
  assign unity_hit = 1'b0;
`endif

  assign in_ready  = (state == S_IDLE);
  assign out_valid = out_valid_q;

  always_comb begin
    fpu_en     = 1'b0;
    fpu_in1    = 32'h0;
    fpu_in2    = 32'h0;
    fpu_opcode = OP_MUL;
    if (state == S_CALC) begin
      fpu_en = 1'b1;
      case (step)
        3'd0: begin fpu_in1 = ar_q; fpu_in2 = wr_q; end
        3'd1: begin fpu_in1 = ai_q; fpu_in2 = wi_q; end
        3'd2: begin fpu_in1 = ar_q; fpu_in2 = wi_q; end
        3'd3: begin fpu_in1 = ai_q; fpu_in2 = wr_q; end
        3'd4: begin fpu_in1 = p0;   fpu_in2 = p1;   fpu_opcode = OP_SUB; end
        3'd5: begin fpu_in1 = p2;   fpu_in2 = p3;   fpu_opcode = OP_ADD; end
        default: fpu_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      step        <= 3'd0;
      ar_q        <= 32'h0;
      ai_q        <= 32'h0;
      wr_q        <= 32'h0;
      wi_q        <= 32'h0;
      p0          <= 32'h0;
      p1          <= 32'h0;
      p2          <= 32'h0;
      p3          <= 32'h0;
      y_re        <= 32'h0;
      y_im        <= 32'h0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            ar_q <= a_re;
            ai_q <= a_im;
            wr_q <= w_re;
            wi_q <= w_im;
            step <= 3'd0;
            if (unity_hit) begin
              y_re  <= a_re;
              y_im  <= a_im;
              state <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          case (step)
            3'd0: p0   <= fpu_out;
            3'd1: p1   <= fpu_out;
            3'd2: p2   <= fpu_out;
            3'd3: p3   <= fpu_out;
            3'd4: y_re <= fpu_out;
            3'd5: y_im <= fpu_out;
            default: ;
          endcase
          if (step == NUM_STEPS - 3'd1) state <= S_DONE;
          else step <= step + 3'd1;
        end
        S_DONE: begin
          // out_valid is registered, so it rises one edge after DONE is entered
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cplx_mul_seq.sv
// tb/tb_cplx_mul_seq.sv - self-checking bench for cplx_mul_seq with a behavioural float FPU
module tb_cplx_mul_seq;
  import cmul_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, fpu_en;
  logic [31:0] a_re, a_im, w_re, w_im, y_re, y_im;
  logic [31:0] fpu_in1, fpu_in2, fpu_out;
  logic [2:0]  fpu_opcode;

  int checks = 0;
  int errors = 0;
  int idle_viol = 0;

  typedef logic [66:0] fpu_rec_t;
  fpu_rec_t mon_q[$];

  typedef struct {
    logic [31:0] ar, ai, wr, wi, yre, yim;
  } vec_t;

  always #5 clk = ~clk;

  cplx_mul_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_re(a_re), .a_im(a_im), .w_re(w_re), .w_im(w_im),
    .out_valid(out_valid), .out_ready(out_ready), .y_re(y_re), .y_im(y_im),
    .fpu_in1(fpu_in1), .fpu_in2(fpu_in2), .fpu_en(fpu_en),
    .fpu_opcode(fpu_opcode), .fpu_out(fpu_out)
  );

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'h00) d = {f[31], 63'd0};
    else if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, f[22:0], 29'd0};
    else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [23:0] m;
    logic [28:0] rest;
    int e;
    d = $realtobits(r);
    if (d[62:52] == 11'h000) return {d[63], 31'd0};
    if (d[62:52] == 11'h7FF) return {d[63], 8'hFF, d[51:29]};
    e = int'(d[62:52]) - 896;
    if (e <= 0) return {d[63], 31'd0};
    m    = {1'b0, d[51:29]};
    rest = d[28:0];
    if (rest > 29'h1000_0000 || (rest == 29'h1000_0000 && m[0])) m = m + 24'd1;
    if (m[23]) begin m = 24'd0; e = e + 1; end
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    return {d[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
    return r2f(f2r(x) * f2r(y));
  endfunction
  function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
    return r2f(f2r(x) + f2r(y));
  endfunction
  function automatic logic [31:0] fsub(input logic [31:0] x, input logic [31:0] y);
    return r2f(f2r(x) - f2r(y));
  endfunction

  function automatic logic [31:0] fpu_model(input logic [31:0] x, input logic [31:0] y,
                                            input logic [2:0] op);
    case (op)
      3'b000:  return fmul(x, y);
      3'b010:  return fadd(x, y);
      3'b011:  return fsub(x, y);
      default: return 32'h0;
    endcase
  endfunction

  assign fpu_out = fpu_model(fpu_in1, fpu_in2, fpu_opcode);

  function automatic logic [31:0] rand_float();
    logic [31:0] f;
    f = $urandom;
    f[30:23] = 8'($urandom_range(110, 140));
    return f;
  endfunction

  function automatic int exp_latency(input logic [31:0] wr, input logic [31:0] wi);
`ifdef CMUL_UNITY_SKIP_EN
    if (wr == 32'h3F80_0000 && wi == 32'h0) return 1;
`endif
    return 7;
  endfunction

  always @(negedge clk) begin
    if (fpu_en) mon_q.push_back({fpu_opcode, fpu_in1, fpu_in2});
    else if ({fpu_opcode, fpu_in1, fpu_in2} != 67'd0) idle_viol++;
  end

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_rec(input string name, input fpu_rec_t act, input fpu_rec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge with the block idle; leaves it idle again
  task automatic run_op(input logic [31:0] ar, ai, wr, wi, yre, yim, input int hold);
    int lat;
    int exp_lat;
    fpu_rec_t exp_seq[6];
    logic [31:0] p0, p1, p2, p3;
    exp_lat = exp_latency(wr, wi);
    p0 = fmul(ar, wr); p1 = fmul(ai, wi); p2 = fmul(ar, wi); p3 = fmul(ai, wr);
    exp_seq[0] = {OP_MUL, ar, wr};
    exp_seq[1] = {OP_MUL, ai, wi};
    exp_seq[2] = {OP_MUL, ar, wi};
    exp_seq[3] = {OP_MUL, ai, wr};
    exp_seq[4] = {OP_SUB, p0, p1};
    exp_seq[5] = {OP_ADD, p2, p3};
    mon_q.delete();
    check1("in_ready_before", in_ready, 1'b1);
    a_re = ar; a_im = ai; w_re = wr; w_im = wi; in_valid = 1'b1;
    tick();
    // scribble on the inputs while busy; none of it may be taken
    a_re = $urandom; a_im = $urandom; w_re = $urandom; w_im = $urandom;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check32("latency", 32'(lat), 32'(exp_lat));
    check32("y_re", y_re, yre);
    check32("y_im", y_im, yim);
    for (int i = 0; i < hold; i++) begin
      tick();
      check1("hold_out_valid", out_valid, 1'b1);
      check1("hold_in_ready", in_ready, 1'b0);
      check32("hold_y_re", y_re, yre);
      check32("hold_y_im", y_im, yim);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check1("in_ready_after", in_ready, 1'b1);
    check1("out_valid_after", out_valid, 1'b0);
    check32("fpu_ops", 32'(mon_q.size()), (exp_lat == 1) ? 32'd0 : 32'd6);
    if (exp_lat != 1 && mon_q.size() == 6)
      for (int i = 0; i < 6; i++) check_rec($sformatf("fpu_step%0d", i), mon_q[i], exp_seq[i]);
  endtask

  initial begin
    vec_t vecs[4];
    logic [31:0] ar, ai, wr, wi;

    vecs[0] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'hC0A0_0000, 32'h4120_0000};
    vecs[1] = '{32'h40A0_0000, 32'hC040_0000, 32'h3F80_0000, 32'h0000_0000, 32'h40A0_0000, 32'hC040_0000};
    vecs[2] = '{32'h4000_0000, 32'h0000_0000, 32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, 32'h4000_0000};
    vecs[3] = '{32'h3F00_0000, 32'hBFC0_0000, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 32'hC000_0000};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_re = 32'h0; a_im = 32'h0; w_re = 32'h0; w_im = 32'h0;
    repeat (3) tick();
    rst = 1'b0;
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_out_valid", out_valid, 1'b0);
    check32("rst_y_re", y_re, 32'h0);
    check32("rst_y_im", y_im, 32'h0);
    check1("rst_fpu_en", fpu_en, 1'b0);

    for (int i = 0; i < 4; i++)
      run_op(vecs[i].ar, vecs[i].ai, vecs[i].wr, vecs[i].wi, vecs[i].yre, vecs[i].yim, (i == 0) ? 5 : i);

    for (int i = 0; i < 12; i++) begin
      ar = rand_float(); ai = rand_float(); wr = rand_float(); wi = rand_float();
      run_op(ar, ai, wr, wi, fsub(fmul(ar, wr), fmul(ai, wi)), fadd(fmul(ar, wi), fmul(ai, wr)),
             int'($urandom_range(0, 3)));
    end
    ar = rand_float(); ai = rand_float();
    run_op(ar, ai, FP_ONE, 32'h0, fsub(fmul(ar, FP_ONE), fmul(ai, 32'h0)),
           fadd(fmul(ar, 32'h0), fmul(ai, FP_ONE)), 1);

    // abort in the middle of a calculation
    a_re = 32'h3F80_0000; a_im = 32'h4000_0000; w_re = 32'h4040_0000; w_im = 32'h4080_0000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check_rec("step3_ports", {fpu_opcode, fpu_in1, fpu_in2}, {OP_MUL, 32'h4000_0000, 32'h4040_0000});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check1("abort_in_ready", in_ready, 1'b1);
    check1("abort_out_valid", out_valid, 1'b0);
    check32("abort_y_re", y_re, 32'h0);
    check32("abort_y_im", y_im, 32'h0);
    check1("abort_fpu_en", fpu_en, 1'b0);
    repeat (8) begin
      tick();
      check1("abort_no_output", out_valid, 1'b0);
    end
    run_op(vecs[3].ar, vecs[3].ai, vecs[3].wr, vecs[3].wi, vecs[3].yre, vecs[3].yim, 2);

    check32("fpu_idle_zero", 32'(idle_viol), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
